// File: rtl/chacha20_poly1305_core.sv
// rtl/chacha20_poly1305_core.sv - ChaCha20 block engine with running Poly1305 MAC
module chacha20_poly1305_core (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         init,
    input  logic         encdec,
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [511:0] data_in,
    output logic         ready,
    output logic         valid,
    output logic         tag_ok,
    output logic [511:0] data_out,
    output logic [127:0] tag
);
    typedef enum logic [2:0] {S_IDLE, S_KEYGEN, S_ROUNDS, S_FINAL, S_POLY, S_DONE} state_t;

    localparam logic [129:0] P1305 = {2'b11, {124{1'b1}}, 4'b1011};
    localparam logic [127:0] CLAMP = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [127:0] bswap128(input logic [127:0] v);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = v[127-8*i -: 8];
        return o;
    endfunction

    // Key/nonce bytes arrive big-endian on the ports; state words are little-endian.
    function automatic logic [15:0][31:0] init_state(input logic [255:0] k, input logic [95:0] n,
                                                     input logic [31:0] c);
        logic [15:0][31:0] s;
        s[0] = 32'h61707865;
        s[1] = 32'h3320646e;
        s[2] = 32'h79622d32;
        s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4+i] = bswap32(k[255-32*i -: 32]);
        s[12] = c;
        for (int i = 0; i < 3; i++) s[13+i] = bswap32(n[95-32*i -: 32]);
        return s;
    endfunction

    function automatic logic [127:0] qr(input logic [31:0] a_i, input logic [31:0] b_i,
                                        input logic [31:0] c_i, input logic [31:0] d_i);
        logic [31:0] a, b, c, d;
        a = a_i; b = b_i; c = c_i; d = d_i;
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        return {a, b, c, d};
    endfunction

    function automatic logic [15:0][31:0] chacha_round(input logic [15:0][31:0] v, input logic diag);
        logic [15:0][31:0] y;
        y = v;
        if (!diag) begin
            {y[0], y[4], y[8],  y[12]} = qr(v[0], v[4], v[8],  v[12]);
            {y[1], y[5], y[9],  y[13]} = qr(v[1], v[5], v[9],  v[13]);
            {y[2], y[6], y[10], y[14]} = qr(v[2], v[6], v[10], v[14]);
            {y[3], y[7], y[11], y[15]} = qr(v[3], v[7], v[11], v[15]);
        end else begin
            {y[0], y[5], y[10], y[15]} = qr(v[0], v[5], v[10], v[15]);
            {y[1], y[6], y[11], y[12]} = qr(v[1], v[6], v[11], v[12]);
            {y[2], y[7], y[8],  y[13]} = qr(v[2], v[7], v[8],  v[13]);
            {y[3], y[4], y[9],  y[14]} = qr(v[3], v[4], v[9],  v[14]);
        end
        return y;
    endfunction

    // Two folds by 2^130 == 5 then one conditional subtract leave acc fully reduced.
    function automatic logic [129:0] poly_step(input logic [129:0] acc_i, input logic [127:0] blk,
                                               input logic [127:0] r_i);
        logic [130:0] a;
        logic [258:0] prod;
        logic [130:0] f1;
        logic [130:0] f2;
        a    = {1'b0, acc_i} + {3'b001, blk};
        prod = {128'b0, a} * {131'b0, r_i};
        f1   = {1'b0, prod[129:0]} + {2'b00, prod[258:130]} + {prod[258:130], 2'b00};
        f2   = {1'b0, f1[129:0]} + {128'b0, f1[130], 1'b0, f1[130]};
        if (f2 >= {1'b0, P1305}) f2 = f2 - {1'b0, P1305};
        return f2[129:0];
    endfunction

    state_t            state;
    logic [4:0]        rcnt;
    logic [15:0][31:0] x;
    logic [31:0]       blk_ctr;
    logic [255:0]      key_l;
    logic [95:0]       nonce_l;
    logic              have_ctx;
    logic              enc_l;
    logic [511:0]      dbuf;
    logic [129:0]      acc;
    logic [127:0]      poly_r;
    logic [127:0]      poly_s;

    logic [15:0][31:0] init_cur;
    logic [15:0][31:0] ks_sum;
    logic [511:0]      ks_bytes;
    logic [511:0]      out_blk;
    logic              msg_start;

    always_comb begin
        init_cur = init_state(key_l, nonce_l, blk_ctr);
        ks_bytes = '0;
        for (int i = 0; i < 16; i++) begin
            ks_sum[i] = x[i] + init_cur[i];
            ks_bytes[511-32*i -: 32] = bswap32(ks_sum[i]);
        end
    end

    assign out_blk   = dbuf ^ ks_bytes;
    assign msg_start = !have_ctx || (key != key_l) || (nonce != nonce_l);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            rcnt     <= '0;
            x        <= '0;
            blk_ctr  <= '0;
            key_l    <= '0;
            nonce_l  <= '0;
            have_ctx <= 1'b0;
            enc_l    <= 1'b0;
            dbuf     <= '0;
            acc      <= '0;
            poly_r   <= '0;
            poly_s   <= '0;
            ready    <= 1'b1;
            valid    <= 1'b0;
            tag_ok   <= 1'b0;
            data_out <= '0;
            tag      <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                S_IDLE: if (init) begin
                    ready  <= 1'b0;
                    tag_ok <= 1'b0;
                    enc_l  <= encdec;
                    dbuf   <= data_in;
                    rcnt   <= '0;
                    if (msg_start) begin
                        have_ctx <= 1'b1;
                        key_l    <= key;
                        nonce_l  <= nonce;
                        acc      <= '0;
                        blk_ctr  <= '0;
                        x        <= init_state(key, nonce, 32'd0);
                        state    <= S_KEYGEN;
                    end else begin
                        blk_ctr <= blk_ctr + 32'd1;
                        x       <= init_state(key_l, nonce_l, blk_ctr + 32'd1);
                        state   <= S_ROUNDS;
                    end
                end
                S_KEYGEN: begin
                    if (rcnt == 5'd20) begin
                        poly_r  <= {ks_sum[3], ks_sum[2], ks_sum[1], ks_sum[0]} & CLAMP;
                        poly_s  <= {ks_sum[7], ks_sum[6], ks_sum[5], ks_sum[4]};
                        blk_ctr <= 32'd1;
                        x       <= init_state(key_l, nonce_l, 32'd1);
                        rcnt    <= '0;
                        state   <= S_ROUNDS;
                    end else begin
                        x    <= chacha_round(x, rcnt[0]);
                        rcnt <= rcnt + 5'd1;
                    end
                end
                S_ROUNDS: begin
                    x <= chacha_round(x, rcnt[0]);
                    if (rcnt == 5'd19) begin
                        rcnt  <= '0;
                        state <= S_FINAL;
                    end else begin
                        rcnt <= rcnt + 5'd1;
                    end
                end
                S_FINAL: begin
                    // x is free once the keystream is consumed, so it holds the result block.
                    x <= out_blk;
                    if (enc_l) dbuf <= out_blk;
                    rcnt  <= '0;
                    state <= S_POLY;
                end
                S_POLY: begin
                    acc  <= poly_step(acc, bswap128(dbuf[511:384]), poly_r);
                    dbuf <= {dbuf[383:0], 128'b0};
                    if (rcnt == 5'd3) begin
                        rcnt  <= '0;
                        state <= S_DONE;
                    end else begin
                        rcnt <= rcnt + 5'd1;
                    end
                end
                S_DONE: begin
                    data_out <= x;
                    tag      <= bswap128(acc[127:0] + poly_s);
                    valid    <= 1'b1;
                    tag_ok   <= 1'b1;
                    ready    <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_chacha20_poly1305_core.sv
// tb/tb_chacha20_poly1305_core.sv - randomized self-checking bench against a byte-level RFC 8439 model
module tb_chacha20_poly1305_core;
    logic         clk = 1'b0;
    logic         reset_n;
    logic         init;
    logic         encdec;
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [511:0] data_in;
    logic         ready;
    logic         valid;
    logic         tag_ok;
    logic [511:0] data_out;
    logic [127:0] tag;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    chacha20_poly1305_core dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .init     (init),
        .encdec   (encdec),
        .key      (key),
        .nonce    (nonce),
        .data_in  (data_in),
        .ready    (ready),
        .valid    (valid),
        .tag_ok   (tag_ok),
        .data_out (data_out),
        .tag      (tag)
    );

    logic         m_have;
    logic [255:0] m_key;
    logic [95:0]  m_nonce;
    int unsigned  m_ctr;
    logic [129:0] m_acc;
    logic [127:0] m_r;
    logic [127:0] m_s;
    int unsigned  mx[16];

    function automatic int unsigned rotl(input int unsigned v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic void m_qr(input int a, input int b, input int c, input int d);
        mx[a] += mx[b]; mx[d] = rotl(mx[d] ^ mx[a], 16);
        mx[c] += mx[d]; mx[b] = rotl(mx[b] ^ mx[c], 12);
        mx[a] += mx[b]; mx[d] = rotl(mx[d] ^ mx[a], 8);
        mx[c] += mx[d]; mx[b] = rotl(mx[b] ^ mx[c], 7);
    endfunction

    function automatic logic [511:0] m_chacha(input logic [255:0] k, input logic [95:0] n,
                                              input int unsigned ctr);
        int unsigned st[16];
        logic [511:0] ks;
        st[0] = 32'h61707865; st[1] = 32'h3320646e; st[2] = 32'h79622d32; st[3] = 32'h6b206574;
        for (int i = 4; i < 16; i++) st[i] = 0;
        for (int j = 0; j < 32; j++) st[4 + j/4] |= 32'(k[255-8*j -: 8]) << (8*(j%4));
        st[12] = ctr;
        for (int j = 0; j < 12; j++) st[13 + j/4] |= 32'(n[95-8*j -: 8]) << (8*(j%4));
        for (int i = 0; i < 16; i++) mx[i] = st[i];
        for (int dr = 0; dr < 10; dr++) begin
            m_qr(0, 4, 8, 12); m_qr(1, 5, 9, 13); m_qr(2, 6, 10, 14); m_qr(3, 7, 11, 15);
            m_qr(0, 5, 10, 15); m_qr(1, 6, 11, 12); m_qr(2, 7, 8, 13); m_qr(3, 4, 9, 14);
        end
        ks = '0;
        for (int b = 0; b < 64; b++) ks[511-8*b -: 8] = 8'((mx[b/4] + st[b/4]) >> (8*(b%4)));
        return ks;
    endfunction

    function automatic logic [263:0] le_num(input logic [511:0] blk, input int off, input int len);
        logic [263:0] v;
        v = '0;
        for (int b = len - 1; b >= 0; b--) v = (v << 8) | 264'(blk[511-8*(off+b) -: 8]);
        return v;
    endfunction

    task automatic m_step(input logic enc, input logic [511:0] din,
                          output logic [511:0] exp_out, output logic [127:0] exp_tag);
        logic [511:0] ks;
        logic [511:0] mac;
        logic [263:0] p;
        logic [263:0] a;
        logic [263:0] t;
        p = (264'd1 << 130) - 264'd5;
        if (!m_have || key !== m_key || nonce !== m_nonce) begin
            m_have  = 1'b1;
            m_key   = key;
            m_nonce = nonce;
            ks      = m_chacha(key, nonce, 0);
            m_r     = 128'(le_num(ks, 0, 16)) & 128'h0ffffffc0ffffffc0ffffffc0fffffff;
            m_s     = 128'(le_num(ks, 16, 16));
            m_acc   = '0;
            m_ctr   = 1;
        end else begin
            m_ctr = m_ctr + 1;
        end
        ks      = m_chacha(m_key, m_nonce, m_ctr);
        exp_out = din ^ ks;
        mac     = enc ? exp_out : din;
        for (int c = 0; c < 4; c++) begin
            a     = 264'(m_acc) + le_num(mac, 16*c, 16) + (264'd1 << 128);
            t     = (a * 264'(m_r)) % p;
            m_acc = 130'(t);
        end
        t       = 264'(m_acc) + 264'(m_s);
        exp_tag = '0;
        for (int b = 0; b < 16; b++) exp_tag[127-8*b -: 8] = 8'(t >> (8*b));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        init    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        m_have  = 1'b0;
        @(negedge clk);
    endtask

    // Accepts init on the next edge; returns edges to valid and whether ready/tag_ok rose while busy.
    task automatic run_block(input logic enc, input logic [511:0] din, input bit poke,
                             output int lat, output bit rdy_seen, output bit tagok_seen);
        encdec  = enc;
        data_in = din;
        init    = 1'b1;
        @(posedge clk);
        #1;
        init    = 1'b0;
        encdec  = 1'($urandom_range(0, 1));
        for (int i = 0; i < 16; i++) data_in[32*i +: 32] = $urandom;
        rdy_seen   = ready;
        tagok_seen = tag_ok;
        lat = 0;
        while (lat < 100) begin
            if (poke) init = (lat >= 3 && lat < 8);
            @(posedge clk);
            #1;
            lat++;
            if (valid) break;
            if (ready) rdy_seen = 1'b1;
            if (tag_ok) tagok_seen = 1'b1;
        end
        init = 1'b0;
    endtask

    logic [511:0] ct[2];
    logic [127:0] tg[2];
    logic [511:0] pt[2];

    task automatic test_reset();
        do_reset();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (tag_ok !== 1'b0) begin errors++; $display("FAIL reset_tag_ok: got %b expected 0", tag_ok); end
        checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data_out: got %h expected 0", data_out); end
        checks++; if (tag !== '0) begin errors++; $display("FAIL reset_tag: got %h expected 0", tag); end
    endtask

    task automatic test_keystream();
        logic [511:0] eo;
        logic [127:0] et;
        int lat;
        bit rs, ts;
        for (int i = 0; i < 32; i++) key[255-8*i -: 8] = 8'(i);
        nonce = 96'h000000090000004a00000000;
        run_block(1'b1, '0, 1'b0, lat, rs, ts);
        m_step(1'b1, '0, eo, et);
        checks++; if (lat !== 47) begin errors++; $display("FAIL ks_latency: got %0d expected 47", lat); end
        checks++; if (data_out[511:384] !== 128'h10f1e7e4d13b5915500fdd1fa32071c4) begin
            errors++; $display("FAIL ks_rfc_prefix: got %h expected 10f1e7e4d13b5915500fdd1fa32071c4", data_out[511:384]);
        end
        checks++; if (data_out !== eo) begin errors++; $display("FAIL ks_block: got %h expected %h", data_out, eo); end
        checks++; if (tag !== et) begin errors++; $display("FAIL ks_tag: got %h expected %h", tag, et); end
        checks++; if (tag_ok !== 1'b1) begin errors++; $display("FAIL ks_tag_ok: got %b expected 1", tag_ok); end
        checks++; if (rs !== 1'b0) begin errors++; $display("FAIL ks_ready_busy: got %b expected 0", rs); end
    endtask

    task automatic test_two_blocks();
        logic [511:0] eo;
        logic [127:0] et;
        int lat;
        bit rs, ts;
        key   = {4{64'h0123456789abcdef}};
        nonce = 96'h111111112222222233333333;
        pt[0] = {8{64'hcafebabedeadbeef}};
        pt[1] = {8{64'h0123456789abcdef}};
        for (int b = 0; b < 2; b++) begin
            run_block(1'b1, pt[b], 1'b0, lat, rs, ts);
            m_step(1'b1, pt[b], eo, et);
            ct[b] = eo;
            tg[b] = et;
            checks++; if (lat !== (b == 0 ? 47 : 26)) begin errors++; $display("FAIL two_latency%0d: got %0d expected %0d", b, lat, (b == 0 ? 47 : 26)); end
            checks++; if (rs !== 1'b0) begin errors++; $display("FAIL two_ready_busy%0d: got %b expected 0", b, rs); end
            checks++; if (ts !== 1'b0) begin errors++; $display("FAIL two_tag_ok_busy%0d: got %b expected 0", b, ts); end
            checks++; if (data_out !== eo) begin errors++; $display("FAIL two_data%0d: got %h expected %h", b, data_out, eo); end
            checks++; if (tag !== et) begin errors++; $display("FAIL two_tag%0d: got %h expected %h", b, tag, et); end
        end
        checks++; if (tg[0] === tg[1]) begin errors++; $display("FAIL two_tags_differ: got %h expected not %h", tg[1], tg[0]); end
    endtask

    task automatic test_round_trip();
        logic [511:0] eo;
        logic [127:0] et;
        int lat;
        bit rs, ts;
        do_reset();
        for (int b = 0; b < 2; b++) begin
            run_block(1'b0, ct[b], 1'b0, lat, rs, ts);
            m_step(1'b0, ct[b], eo, et);
            checks++; if (lat !== (b == 0 ? 47 : 26)) begin errors++; $display("FAIL rt_latency%0d: got %0d expected %0d", b, lat, (b == 0 ? 47 : 26)); end
            checks++; if (data_out !== pt[b]) begin errors++; $display("FAIL rt_plain%0d: got %h expected %h", b, data_out, pt[b]); end
            checks++; if (tag !== tg[b]) begin errors++; $display("FAIL rt_tag%0d: got %h expected %h", b, tag, tg[b]); end
        end
    endtask

    task automatic test_busy_init();
        logic [511:0] din, eo;
        logic [127:0] et;
        int lat;
        bit rs, ts;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 16; i++) din[32*i +: 32] = $urandom;
            run_block(1'b1, din, 1'b1, lat, rs, ts);
            m_step(1'b1, din, eo, et);
            checks++; if (lat !== 26) begin errors++; $display("FAIL busy_latency%0d: got %0d expected 26", b, lat); end
            checks++; if (data_out !== eo) begin errors++; $display("FAIL busy_data%0d: got %h expected %h", b, data_out, eo); end
            checks++; if (tag !== et) begin errors++; $display("FAIL busy_tag%0d: got %h expected %h", b, tag, et); end
        end
    endtask

    task automatic test_reset_mid();
        logic [511:0] din, eo;
        logic [127:0] et;
        int lat;
        bit rs, ts, seen_valid;
        for (int i = 0; i < 8; i++) key[32*i +: 32] = $urandom;
        for (int i = 0; i < 16; i++) din[32*i +: 32] = $urandom;
        encdec  = 1'b1;
        data_in = din;
        init    = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
        seen_valid = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (valid) seen_valid = 1'b1;
        end
        reset_n = 1'b0;
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", ready); end
        checks++; if (tag_ok !== 1'b0) begin errors++; $display("FAIL mid_tag_ok: got %b expected 0", tag_ok); end
        checks++; if (data_out !== '0) begin errors++; $display("FAIL mid_data_out: got %h expected 0", data_out); end
        checks++; if (tag !== '0) begin errors++; $display("FAIL mid_tag: got %h expected 0", tag); end
        @(negedge clk);
        reset_n = 1'b1;
        m_have  = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (valid) seen_valid = 1'b1;
        end
        checks++; if (seen_valid !== 1'b0) begin errors++; $display("FAIL mid_no_valid: got %b expected 0", seen_valid); end
        run_block(1'b1, din, 1'b0, lat, rs, ts);
        m_step(1'b1, din, eo, et);
        checks++; if (lat !== 47) begin errors++; $display("FAIL mid_restart_latency: got %0d expected 47", lat); end
        checks++; if (data_out !== eo) begin errors++; $display("FAIL mid_restart_data: got %h expected %h", data_out, eo); end
        checks++; if (tag !== et) begin errors++; $display("FAIL mid_restart_tag: got %h expected %h", tag, et); end
    endtask

    task automatic test_random();
        logic [511:0] din, eo;
        logic [127:0] et;
        logic enc;
        int lat, nb;
        bit rs, ts;
        for (int m = 0; m < 4; m++) begin
            for (int i = 0; i < 8; i++) key[32*i +: 32] = $urandom;
            for (int i = 0; i < 3; i++) nonce[32*i +: 32] = $urandom;
            nb = 1 + int'($urandom_range(0, 2));
            for (int b = 0; b < nb; b++) begin
                for (int i = 0; i < 16; i++) din[32*i +: 32] = $urandom;
                enc = 1'($urandom_range(0, 1));
                run_block(enc, din, 1'b0, lat, rs, ts);
                m_step(enc, din, eo, et);
                checks++; if (lat !== (b == 0 ? 47 : 26)) begin errors++; $display("FAIL rnd_latency m%0d b%0d: got %0d expected %0d", m, b, lat, (b == 0 ? 47 : 26)); end
                checks++; if (data_out !== eo) begin errors++; $display("FAIL rnd_data m%0d b%0d: got %h expected %h", m, b, data_out, eo); end
                checks++; if (tag !== et) begin errors++; $display("FAIL rnd_tag m%0d b%0d: got %h expected %h", m, b, tag, et); end
                checks++; if (tag_ok !== 1'b1 || ts !== 1'b0) begin errors++; $display("FAIL rnd_tag_ok m%0d b%0d: got done=%b busy=%b expected done=1 busy=0", m, b, tag_ok, ts); end
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        init    = 1'b0;
        encdec  = 1'b0;
        key     = '0;
        nonce   = '0;
        data_in = '0;
        m_have  = 1'b0;
        m_key   = '0;
        m_nonce = '0;
        m_ctr   = 0;
        m_acc   = '0;
        m_r     = '0;
        m_s     = '0;
        test_reset();
        test_keystream();
        test_two_blocks();
        test_round_trip();
        test_busy_init();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
